// File: rtl/distance_bcd_filter_pkg.sv
// Shared types and widths for the distance display filter.
//   DIST_W     : raw distance sample width (cm)
//   BCD_DIGITS : number of decimal digits produced
//   BCD_W      : packed BCD width
//   state_t    : conversion engine states
package dist_pkg;
  localparam int DIST_W     = 11;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 16;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
endpackage

// File: rtl/distance_bcd_filter_if.sv
// Sample-in / digits-out bundle for distance_bcd_filter.
//   dist_in, dist_valid        : raw sample and its one-cycle strobe
//   bcd_thou..bcd_ones         : displayed digits, held between updates
//   bcd_valid                  : one-cycle pulse when digits update
//   busy                       : conversion engine active
//   out_of_range               : last accepted sample exceeded the clamp
// master = sample producer / display side, slave = the filter.
interface distance_bcd_filter_if;
  import dist_pkg::*;
  logic [DIST_W-1:0] dist_in;
  logic              dist_valid;
  logic [3:0]        bcd_thou;
  logic [3:0]        bcd_hund;
  logic [3:0]        bcd_tens;
  logic [3:0]        bcd_ones;
  logic              bcd_valid;
  logic              busy;
  logic              out_of_range;

  modport master (output dist_in, dist_valid,
                  input  bcd_thou, bcd_hund, bcd_tens, bcd_ones,
                         bcd_valid, busy, out_of_range);
  modport slave  (input  dist_in, dist_valid,
                  output bcd_thou, bcd_hund, bcd_tens, bcd_ones,
                         bcd_valid, busy, out_of_range);
endinterface

// File: rtl/distance_bcd_filter_bin2bcd.sv
// Sequential double-dabble converter: 11-bit binary to 4 BCD digits.
//   clk, rst_n : clock, async active-low reset
//   start      : begin a conversion (honoured only in IDLE)
//   bin        : value captured in the LOAD cycle
//   bcd        : digits, registered on the last shift, held afterwards
//   done       : one-cycle pulse, high during the DONE state
//   busy       : high in LOAD, SHIFT and DONE
module bin2bcd_seq
  import dist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIST_W-1:0] bin,
  output logic [BCD_W-1:0]  bcd,
  output logic              done,
  output logic              busy
);
  localparam int SH_W = BCD_W + DIST_W;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d, sh_adj;
  logic [3:0]        it_q, it_d;
  logic [BCD_W-1:0]  bcd_d;
  logic              done_d;

  // add-3 correction on every BCD nibble before the shift
  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (sh_q[DIST_W+4*i +: 4] >= 4'd5)
        sh_adj[DIST_W+4*i +: 4] = sh_q[DIST_W+4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    it_d    = it_q;
    bcd_d   = bcd;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD: begin
        sh_d    = {{BCD_W{1'b0}}, bin};
        it_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d = {sh_adj[SH_W-2:0], 1'b0};
        it_d = it_q + 4'd1;
        // outputs are captured on the final shift so they are visible
        // during the DONE cycle together with the pulse
        if (it_q == 4'(DIST_W-1)) begin
          bcd_d   = sh_d[SH_W-1 -: BCD_W];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      it_q    <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      it_q    <= it_d;
      bcd     <= bcd_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: rtl/distance_bcd_filter.sv
// Display conditioning for the ultrasonic range: clamp, moving average
// over 2^AVG_LOG2 samples, then sequential binary-to-BCD conversion.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of distance_bcd_filter_if (samples in, digits out)
// Parameters: AVG_LOG2 (average depth log2), MAX_CM (clamp ceiling).
module distance_bcd_filter
  import dist_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_CM   = 400
) (
  input  logic                 clk,
  input  logic                 rst_n,
  distance_bcd_filter_if.slave bus
);
  localparam int N     = 1 << AVG_LOG2;
  // pointer is at least 1 bit; ring storage is padded to 2^WP_W so the
  // pointer always indexes it at full width (unused slot stays zero)
  localparam int WP_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int RING  = 1 << WP_W;
  localparam int SUM_W = DIST_W + AVG_LOG2;
  localparam int FC_W  = AVG_LOG2 + 1;

  logic [RING-1:0][DIST_W-1:0] ring_q;
  logic [WP_W-1:0]             wp_q;
  logic [SUM_W-1:0]            sum_q;
  logic [FC_W-1:0]             fill_q;
  logic                        pending_q, oor_q;

  logic                        over;
  logic [DIST_W-1:0]           s_clamp, avg;
  logic                        pend_set, start;
  logic [BCD_W-1:0]            bcd;
  logic                        eng_done, eng_busy;

  assign over     = bus.dist_in > DIST_W'(MAX_CM);
  assign s_clamp  = over ? DIST_W'(MAX_CM) : bus.dist_in;
  // this sample is the N-th (or later) since reset
  assign pend_set = bus.dist_valid && (fill_q >= FC_W'(N-1));
  assign start    = pending_q && !eng_busy;
  assign avg      = DIST_W'(sum_q >> AVG_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_q    <= '0;
      wp_q      <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      oor_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      if (bus.dist_valid) begin
        sum_q        <= sum_q - SUM_W'(ring_q[wp_q]) + SUM_W'(s_clamp);
        ring_q[wp_q] <= s_clamp;
        wp_q         <= (wp_q == WP_W'(N-1)) ? '0 : wp_q + WP_W'(1);
        oor_q        <= over;
        if (fill_q != FC_W'(N)) fill_q <= fill_q + FC_W'(1);
      end
      // a new qualifying sample wins over the clear; extras coalesce
      if (pend_set)   pending_q <= 1'b1;
      else if (start) pending_q <= 1'b0;
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (avg),
    .bcd   (bcd),
    .done  (eng_done),
    .busy  (eng_busy)
  );

  assign bus.bcd_thou     = bcd[15:12];
  assign bus.bcd_hund     = bcd[11:8];
  assign bus.bcd_tens     = bcd[7:4];
  assign bus.bcd_ones     = bcd[3:0];
  assign bus.bcd_valid    = eng_done;
  assign bus.busy         = eng_busy;
  assign bus.out_of_range = oor_q;
endmodule
